// File: rtl/wm8731_cfg_sequencer_if.sv
// wm8731_cfg_sequencer_if: command/data stream bundle between the codec sequencer and the i2c_master
interface wm8731_cfg_sequencer_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       data_out_last;
  logic       i2c_busy;
  logic       missed_ack;
  modport master (
    output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid,
    output data_out, data_out_valid, data_out_last,
    input  cmd_ready, data_out_ready, i2c_busy, missed_ack
  );
  modport slave (
    input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid,
    input  data_out, data_out_valid, data_out_last,
    output cmd_ready, data_out_ready, i2c_busy, missed_ack
  );
endinterface

// File: rtl/wm8731_cfg_sequencer.sv
// wm8731_cfg_sequencer: boots the WM8731 over I2C, then serves runtime register writes with retry and a shadow copy
module wm8731_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [8:0] req_data,
  output logic       busy,
  output logic       boot_done,
  output logic       error,
  input  logic [3:0] shadow_addr,
  output logic [8:0] shadow_data,
  wm8731_cfg_sequencer_if.master i2c
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE_BOOT, LOAD, CMD, DATA0, DATA1, WAIT_DONE, GAP, IDLE_RUN} state_t;
  state_t        state;
  logic [3:0]    idx;
  logic [6:0]    addr;
  logic [8:0]    data;
  logic [RW-1:0] retry;
  logic          nack;
  logic [1:0]    wcnt;
  logic [GW-1:0] gcnt;
  logic [8:0]    shadow [16];
  function automatic logic [15:0] boot_entry(input logic [3:0] i);
    case (i)
      4'd0:    boot_entry = {7'd15, 9'h000};
      4'd1:    boot_entry = {7'd6,  9'h000};
      4'd2:    boot_entry = {7'd0,  9'h017};
      4'd3:    boot_entry = {7'd1,  9'h017};
      4'd4:    boot_entry = {7'd2,  9'h079};
      4'd5:    boot_entry = {7'd3,  9'h079};
      4'd6:    boot_entry = {7'd4,  9'h012};
      4'd7:    boot_entry = {7'd5,  9'h000};
      4'd8:    boot_entry = {7'd7,  9'h00A};
      4'd9:    boot_entry = {7'd8,  9'h000};
      4'd10:   boot_entry = {7'd9,  9'h001};
      default: boot_entry = '0;
    endcase
  endfunction
  assign i2c.cmd_address        = DEV_ADDR;
  assign i2c.cmd_start          = 1'b1;
  assign i2c.cmd_write_multiple = 1'b1;
  assign i2c.cmd_stop           = 1'b1;
  assign i2c.cmd_read           = 1'b0;
  assign i2c.cmd_write          = 1'b0;
  assign shadow_data            = shadow[shadow_addr];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE_BOOT;
      idx                <= '0;
      addr               <= '0;
      data               <= '0;
      retry              <= '0;
      nack               <= 1'b0;
      wcnt               <= '0;
      gcnt               <= '0;
      req_ready          <= 1'b0;
      busy               <= 1'b0;
      boot_done          <= 1'b0;
      error              <= 1'b0;
      i2c.cmd_valid      <= 1'b0;
      i2c.data_out       <= '0;
      i2c.data_out_valid <= 1'b0;
      i2c.data_out_last  <= 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else begin
      // a NACK anywhere in the transaction window condemns the whole write
      if (state inside {CMD, DATA0, DATA1, WAIT_DONE} && i2c.missed_ack) nack <= 1'b1;
      case (state)
        IDLE_BOOT: if (start) begin
          idx   <= '0;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          if (!boot_done) {addr, data} <= boot_entry(idx);
          retry         <= '0;
          nack          <= 1'b0;
          i2c.cmd_valid <= 1'b1;
          state         <= CMD;
        end
        CMD: if (i2c.cmd_ready) begin
          i2c.cmd_valid      <= 1'b0;
          i2c.data_out       <= {addr, data[8]};
          i2c.data_out_valid <= 1'b1;
          state              <= DATA0;
        end
        DATA0: if (i2c.data_out_ready) begin
          i2c.data_out      <= data[7:0];
          i2c.data_out_last <= 1'b1;
          state             <= DATA1;
        end
        DATA1: if (i2c.data_out_ready) begin
          i2c.data_out_valid <= 1'b0;
          i2c.data_out_last  <= 1'b0;
          wcnt               <= '0;
          state              <= WAIT_DONE;
        end
        // the master needs a couple of cycles before i2c_busy reflects the new transfer
        WAIT_DONE: if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
          else if (!i2c.i2c_busy) begin
            gcnt  <= '0;
            state <= GAP;
          end
        GAP: if (gcnt != GW'(GAP_CYCLES - 1)) gcnt <= gcnt + 1'b1;
          else if (nack && retry != RW'(MAX_RETRY)) begin
            retry         <= retry + 1'b1;
            nack          <= 1'b0;
            i2c.cmd_valid <= 1'b1;
            state         <= CMD;
          end else begin
            if (nack) error <= 1'b1;
            else if (addr[6:4] == 3'd0) shadow[addr[3:0]] <= data;
            if (!boot_done && idx != 4'd10) begin
              idx   <= idx + 4'd1;
              state <= LOAD;
            end else begin
              boot_done <= 1'b1;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE_RUN;
            end
          end
        IDLE_RUN: if (req_valid) begin
          addr      <= req_addr;
          data      <= req_data;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= LOAD;
        end
        default: state <= IDLE_BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_wm8731_cfg_sequencer.sv
// tb_wm8731_cfg_sequencer: directed bench acting as the i2c_master side of the WM8731 config sequencer
module tb_wm8731_cfg_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic [8:0] req_data = '0;
  logic [3:0] shadow_addr = '0;
  logic       req_ready, busy, boot_done, error;
  logic [8:0] shadow_data;
  int         checks = 0;
  int         failures = 0;
  int         n;
  localparam logic [6:0] TA [11] = '{7'd15, 7'd6, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd7, 7'd8, 7'd9};
  localparam logic [8:0] TD [11] = '{9'h000, 9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h00A, 9'h000, 9'h001};
  wm8731_cfg_sequencer_if i2c();
  wm8731_cfg_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .boot_done(boot_done), .error(error),
    .shadow_addr(shadow_addr), .shadow_data(shadow_data), .i2c(i2c)
  );
  always #5 clock = ~clock;
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic shd(input logic [3:0] a, input logic [8:0] e);
    shadow_addr = a;
    #1;
    chk($sformatf("shadow[%0d]", a), shadow_data, e);
  endtask
  task automatic wait_ready(input string tag);
    int k = 0;
    while (!req_ready && k < 300) begin @(negedge clock); k++; end
    chk({tag, " req_ready"}, req_ready, 1);
  endtask
  // plays one write as the i2c_master: optional stalls, optional NACK, byte-by-byte checks
  task automatic txn(input string tag, input logic [6:0] ea, input logic [8:0] ed, input bit nack, input int cs, input int ds);
    int k = 0;
    i2c.cmd_ready = (cs == 0);
    i2c.data_out_ready = (ds == 0);
    while (!i2c.cmd_valid && k < 300) begin @(negedge clock); k++; end
    chk({tag, " cmd_valid"}, i2c.cmd_valid, 1);
    if (!i2c.cmd_valid) return;
    chk({tag, " busy"}, busy, 1);
    for (int i = 0; i < cs; i++) begin
      @(negedge clock);
      chk({tag, " cmd held"}, {i2c.cmd_valid, i2c.data_out_valid}, 2'b10);
    end
    i2c.cmd_ready = 1'b1;
    @(negedge clock);
    chk({tag, " byte0"}, {i2c.cmd_valid, i2c.data_out_valid, i2c.data_out_last, i2c.data_out}, {3'b010, ea, ed[8]});
    for (int i = 0; i < ds; i++) begin
      @(negedge clock);
      chk({tag, " byte0 held"}, {i2c.data_out_valid, i2c.data_out_last, i2c.data_out}, {2'b10, ea, ed[8]});
    end
    i2c.data_out_ready = 1'b1;
    i2c.missed_ack = nack;
    @(negedge clock);
    i2c.missed_ack = 1'b0;
    chk({tag, " byte1"}, {i2c.data_out_valid, i2c.data_out_last, i2c.data_out}, {2'b11, ed[7:0]});
    @(negedge clock);
    chk({tag, " end"}, {i2c.cmd_valid, i2c.data_out_valid, i2c.data_out_last}, 3'b000);
  endtask
  initial begin
    i2c.cmd_ready = 1'b1;
    i2c.data_out_ready = 1'b1;
    i2c.i2c_busy = 1'b0;
    i2c.missed_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst outs", {req_ready, busy, boot_done, error, i2c.cmd_valid, i2c.data_out_valid, i2c.data_out_last}, 0);
    chk("rst data_out", i2c.data_out, 0);
    chk("rst cmd_address", i2c.cmd_address, 7'h1A);
    shd(4'd9, 9'h000);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("idle_boot", {req_ready, busy, i2c.cmd_valid}, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("boot busy", busy, 1);
    chk("flags", {i2c.cmd_start, i2c.cmd_read, i2c.cmd_write, i2c.cmd_write_multiple, i2c.cmd_stop}, 5'b10011);
    for (int i = 0; i < 11; i++)
      txn($sformatf("boot1 R%0d", TA[i]), TA[i], TD[i], 1'b0, TA[i] == 7'd7 ? 20 : 0, TA[i] == 7'd7 ? 10 : 0);
    @(negedge clock);
    chk("boot1 gap", {req_ready, busy}, 2'b01);
    wait_ready("boot1");
    chk("boot1 done", {boot_done, error, busy}, 3'b100);
    shd(4'd9, 9'h001);
    shd(4'd4, 9'h012);
    shd(4'd7, 9'h00A);
    shd(4'd10, 9'h000);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("start ignored", {busy, i2c.cmd_valid, req_ready}, 3'b001);
    req_addr = 7'd0;
    req_data = 9'h1FF;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    chk("accept", {req_ready, busy}, 2'b01);
    txn("rt0", 7'd0, 9'h1FF, 1'b0, 0, 0);
    @(negedge clock);
    chk("rt0 gap", req_ready, 0);
    wait_ready("rt0");
    shd(4'd0, 9'h1FF);
    req_addr = 7'd20;
    req_data = 9'h055;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    txn("rt20", 7'd20, 9'h055, 1'b0, 0, 0);
    wait_ready("rt20");
    shd(4'd4, 9'h012);
    chk("rt20 error", error, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    i2c.data_out_ready = 1'b0;
    n = 0;
    while (!i2c.data_out_valid && n < 50) begin @(negedge clock); n++; end
    chk("data0 reached", i2c.data_out_valid, 1);
    reset = 1'b1;
    #1;
    chk("async rst", {i2c.data_out_valid, i2c.cmd_valid, boot_done, busy, req_ready}, 0);
    shd(4'd0, 9'h000);
    @(negedge clock);
    reset = 1'b0;
    i2c.data_out_ready = 1'b1;
    repeat (10) @(negedge clock);
    chk("no restart", {busy, i2c.cmd_valid}, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (TA[i] == 7'd2) begin
        txn("R2 nack", TA[i], TD[i], 1'b1, 0, 0);
        txn("R2 retry", TA[i], TD[i], 1'b0, 0, 0);
        chk("R2 error", error, 0);
      end else if (TA[i] == 7'd4) begin
        for (int k = 0; k < 4; k++) txn($sformatf("R4 try%0d", k), TA[i], TD[i], 1'b1, 0, 0);
      end else txn($sformatf("boot2 R%0d", TA[i]), TA[i], TD[i], 1'b0, 0, 0);
    end
    wait_ready("boot2");
    chk("boot2 done", {boot_done, error, busy}, 3'b110);
    shd(4'd2, 9'h079);
    shd(4'd4, 9'h000);
    shd(4'd5, 9'h000);
    shd(4'd0, 9'h017);
    shd(4'd9, 9'h001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
